y86_register_file: RTL and testbench
====================================

Name: y86_register_file

Overview:
- Architectural register file of the Y86-64 core.
- Consumes the four register IDs produced by the decode/write-back ID selectors (srcA, srcB, dstE, dstM) and supplies valA/valB to execute.
- Writes valE/valM back at the clock edge.
- ID 4'hF is the "no register" code: reads of it return zero, writes to it are discarded.

Parameters:
- DATA_WID, 64, width of each register and of all value ports
- ADDR_WID, 4, width of a register ID
- NUM_REGS, 15, architectural registers, IDs 0..14 (%rax..%r14); ID 15 = NonReg
- RSP_ID, 4, ID of %rsp (stack pointer)
- RSP_RESET, 0, reset value loaded into %rsp; all other registers reset to 0

Ports:
- clk  input  1  core clock; all state updates on rising edge
- rst  input  1  asynchronous, active-high reset
- srcA  input  ADDR_WID  read port A register ID
- srcB  input  ADDR_WID  read port B register ID
- valA  output  DATA_WID  contents of srcA (0 when srcA = 4'hF)
- valB  output  DATA_WID  contents of srcB (0 when srcB = 4'hF)
- dstE  input  ADDR_WID  write port E register ID (4'hF = no write)
- valE  input  DATA_WID  write port E data
- dstM  input  ADDR_WID  write port M register ID (4'hF = no write)
- valM  input  DATA_WID  write port M data
- wb_en  input  1  write-back enable; 0 suppresses both writes (stall / bubble in write-back)
- dbg_id  input  ADDR_WID  debug read register ID
- dbg_val  output  DATA_WID  debug read data (0 for 4'hF)
- wr_count  output  32  count of architectural writes committed since reset

Behaviour:
- Storage: NUM_REGS x DATA_WID flops; no entry for ID 15.
- Reset (rst high, asynchronous, any time):
  - All registers cleared to 0; %rsp loaded with RSP_RESET.
  - wr_count = 0.
  - Pending writes in the reset cycle are lost.
  - After reset, valA/valB/dbg_val reflect the reset contents combinationally.
- Reads:
  - Combinational, zero-cycle latency from srcA/srcB/dbg_id to valA/valB/dbg_val.
  - Any ID >= NUM_REGS reads 0.
- Writes, at rising clk when rst low and wb_en high:
  - If dstE != 4'hF: reg[dstE] <= valE.
  - If dstM != 4'hF: reg[dstM] <= valM.
  - If dstE == dstM != 4'hF (e.g. popq %rsp): valM wins, valE discarded; counts as one write.
  - wb_en low: no register changes, wr_count holds.
- wr_count: increments by the number of distinct registers written that cycle (0, 1 or 2). Wraps from 2^32-1 to 0 / 1 without saturation.
- Read-during-write (feature off): a read of a register being written this cycle returns the OLD value. The new value is visible the cycle after the edge.
- Only IDs 4'hF and >= NUM_REGS are ignored on write; no X propagation from unused IDs.

Optional Feature:
- Macro: REGFILE_BYPASS_EN
- Defined: write-through bypass on valA, valB and dbg_val.
  - If the read ID equals a valid write ID with wb_en high, the read returns the incoming write data in the same cycle.
  - valM takes priority over valE when both match.
  - rst high suppresses the bypass (reads return reset contents).
- Undefined: reads strictly return stored contents as described above.

Test Plan:
- Reset: set RSP_RESET=64'h100, assert rst mid-cycle after writing 5 into %rax -> immediately valA(srcA=0)=0, valB(srcB=4)=64'h100, wr_count=0.
- Dual write: dstE=1/valE=64'hAA, dstM=2/valM=64'hBB, wb_en=1, one edge -> reg1=AA, reg2=BB, wr_count +2.
- Conflict: dstE=dstM=4, valE=8, valM=64'h55 -> %rsp=64'h55, wr_count +1.
- NonReg and stall: dstE=dstM=4'hF for one edge, then dstE=3 with wb_en=0 for one edge -> no register changes, wr_count unchanged; srcA=4'hF reads 0.
- Read-during-write: srcA=dstE=6, valE=64'h77 -> pre-edge valA shows old value without REGFILE_BYPASS_EN, 64'h77 with it; post-edge 64'h77 in both builds.
- Counter wrap: force wr_count to 32'hFFFFFFFF, perform a dual write -> wr_count=1.

Source files
------------

// File: rtl/y86_register_file.sv
// ============================================================================
// Module   : y86_register_file
// Purpose  : Y86-64 architectural register file, two combinational read
//            ports, one debug read port, two write-back ports (E and M).
//            Optional macro REGFILE_BYPASS_EN adds a write-through bypass.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module y86_register_file #(
   parameter int                     DATA_WID  = 64,
   parameter int                     ADDR_WID  = 4,
   parameter int                     NUM_REGS  = 15,
   parameter int                     RSP_ID    = 4,
   parameter logic [DATA_WID-1:0]    RSP_RESET = '0
) (
   input  logic                clk,
   input  logic                rst,
   input  logic [ADDR_WID-1:0] srcA,
   input  logic [ADDR_WID-1:0] srcB,
   output logic [DATA_WID-1:0] valA,
   output logic [DATA_WID-1:0] valB,
   input  logic [ADDR_WID-1:0] dstE,
   input  logic [DATA_WID-1:0] valE,
   input  logic [ADDR_WID-1:0] dstM,
   input  logic [DATA_WID-1:0] valM,
   input  logic                wb_en,
   input  logic [ADDR_WID-1:0] dbg_id,
   output logic [DATA_WID-1:0] dbg_val,
   output logic [31:0]         wr_count
);

   localparam logic [ADDR_WID-1:0] c_nonreg = '1;

   logic [DATA_WID-1:0] r_regs [NUM_REGS];
   logic [31:0]         r_wr_count;

   logic       w_we_e;
   logic       w_we_m;
   logic       w_we_e_eff;
   logic [1:0] w_incr;

   // IDs outside the storage range (including NonReg) never write.
   assign w_we_e     = wb_en && (dstE != c_nonreg) && (32'(dstE) < NUM_REGS);
   assign w_we_m     = wb_en && (dstM != c_nonreg) && (32'(dstM) < NUM_REGS);
   assign w_we_e_eff = w_we_e && !(w_we_m && (dstE == dstM));
   assign w_incr     = {1'b0, w_we_m} + {1'b0, w_we_e_eff};

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < NUM_REGS; i++) begin
            r_regs[i] <= '0;
         end
         r_regs[RSP_ID] <= RSP_RESET;
      end else begin
         if (w_we_e_eff) begin
            r_regs[dstE] <= valE;
         end
         if (w_we_m) begin
            r_regs[dstM] <= valM;
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_wr_count <= '0;
      end else begin
         r_wr_count <= r_wr_count + {30'd0, w_incr};
      end
   end

   function automatic logic [DATA_WID-1:0] f_read(input logic [ADDR_WID-1:0] id);
      logic [DATA_WID-1:0] v;
      v = '0;
      if ((id != c_nonreg) && (32'(id) < NUM_REGS)) begin
         v = r_regs[id];
      end
`ifdef REGFILE_BYPASS_EN
      // M is checked last so it wins when both ports target the same ID.
      if (!rst && w_we_e && (id == dstE)) begin
         v = valE;
      end
      if (!rst && w_we_m && (id == dstM)) begin
         v = valM;
      end
`endif
      return v;
   endfunction

   assign valA     = f_read(srcA);
   assign valB     = f_read(srcB);
   assign dbg_val  = f_read(dbg_id);
   assign wr_count = r_wr_count;

endmodule

`default_nettype wire

// File: tb/tb_y86_register_file.sv
// Directed bench for y86_register_file: bench-side model feeds a scoreboard
// queue that is drained against DUT outputs.
`default_nettype none

module tb_y86_register_file;

   localparam int          DW  = 64;
   localparam int          AW  = 4;
   localparam int          NR  = 15;
   localparam logic [63:0] RSPV = 64'h100;

   logic          clk = 1'b0;
   logic          rst;
   logic [AW-1:0] srcA, srcB, dstE, dstM, dbg_id;
   logic [DW-1:0] valA, valB, valE, valM, dbg_val;
   logic          wb_en;
   logic [31:0]   wr_count;

   int checks   = 0;
   int failures = 0;

   logic [63:0] exp_q [$];
   string       tag_q [$];

   logic [63:0] mdl [NR];
   logic [31:0] mcnt;

   y86_register_file #(
      .DATA_WID (DW),
      .ADDR_WID (AW),
      .NUM_REGS (NR),
      .RSP_ID   (4),
      .RSP_RESET(RSPV)
   ) dut (
      .clk     (clk),
      .rst     (rst),
      .srcA    (srcA),
      .srcB    (srcB),
      .valA    (valA),
      .valB    (valB),
      .dstE    (dstE),
      .valE    (valE),
      .dstM    (dstM),
      .valM    (valM),
      .wb_en   (wb_en),
      .dbg_id  (dbg_id),
      .dbg_val (dbg_val),
      .wr_count(wr_count)
   );

   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL timeout checks=%0d", checks);
      $fatal(1, "timeout");
   end

   function automatic logic [63:0] mread(input logic [AW-1:0] id);
      if (id == 4'hF || int'(id) >= NR) return 64'd0;
      return mdl[id];
   endfunction

   // Value seen before the edge while a write is presented.
   function automatic logic [63:0] mread_pre(input logic [AW-1:0] id);
      logic [63:0] v;
      v = mread(id);
`ifdef REGFILE_BYPASS_EN
      if (!rst && wb_en && dstE != 4'hF && id == dstE) v = valE;
      if (!rst && wb_en && dstM != 4'hF && id == dstM) v = valM;
`endif
      return v;
   endfunction

   task automatic model_reset();
      for (int i = 0; i < NR; i++) mdl[i] = 64'd0;
      mdl[4] = RSPV;
      mcnt   = 32'd0;
   endtask

   task automatic model_commit();
      if (rst || !wb_en) return;
      if (dstM != 4'hF) begin
         mdl[dstM] = valM;
         mcnt      = mcnt + 1;
      end
      if (dstE != 4'hF && dstE != dstM) begin
         mdl[dstE] = valE;
         mcnt      = mcnt + 1;
      end
   endtask

   task automatic push(input string tag, input logic [63:0] e);
      tag_q.push_back(tag);
      exp_q.push_back(e);
   endtask

   task automatic check(input logic [63:0] obs);
      logic [63:0] e;
      string       t;
      checks++;
      if (exp_q.size() == 0) begin
         failures++;
         $error("FAIL scoreboard_empty observed=%h expected=none", obs);
         return;
      end
      e = exp_q.pop_front();
      t = tag_q.pop_front();
      assert (obs === e) else begin
         failures++;
         $error("FAIL %s observed=%h expected=%h", t, obs, e);
      end
   endtask

   // One rising edge with the current inputs; sample 1 time unit later.
   task automatic step();
      @(posedge clk);
      model_commit();
      #1;
   endtask

   initial begin
      rst = 1'b1; wb_en = 1'b0;
      srcA = 4'hF; srcB = 4'hF; dbg_id = 4'hF;
      dstE = 4'hF; dstM = 4'hF; valE = '0; valM = '0;
      model_reset();
      repeat (2) @(posedge clk);
      @(negedge clk);
      rst = 1'b0;

      // Reset contents
      srcA = 4'd0; srcB = 4'd4; dbg_id = 4'hF;
      push("rst_valA", mread(4'd0));
      push("rst_valB_rsp", mread(4'd4));
      push("rst_dbg_nonreg", 64'd0);
      push("rst_count", {32'd0, mcnt});
      #1;
      check(valA); check(valB); check(dbg_val); check({32'd0, wr_count});

      // Write 5 into %rax, then asynchronous reset mid-cycle
      @(negedge clk);
      dstE = 4'd0; valE = 64'd5; wb_en = 1'b1;
      step();
      push("rax_written", 64'd5);
      check(valA);
      #2;
      rst = 1'b1;
      model_reset();
      #1;
      push("async_rst_valA", mread(4'd0));
      push("async_rst_valB", 64'h100);
      push("async_rst_count", 64'd0);
      check(valA); check(valB); check({32'd0, wr_count});
      step();
      @(negedge clk);
      rst = 1'b0; wb_en = 1'b0;
      push("rst_write_lost", 64'd0);
      #1;
      check(valA);

      // Dual write
      @(negedge clk);
      dstE = 4'd1; valE = 64'hAA; dstM = 4'd2; valM = 64'hBB; wb_en = 1'b1;
      srcA = 4'd1; srcB = 4'd2;
      step();
      push("dual_reg1", mread(4'd1));
      push("dual_reg2", mread(4'd2));
      push("dual_count", {32'd0, mcnt});
      check(valA); check(valB); check({32'd0, wr_count});

      // Same destination on both ports: M wins, one write
      @(negedge clk);
      dstE = 4'd4; valE = 64'd8; dstM = 4'd4; valM = 64'h55;
      dbg_id = 4'd4;
      step();
      push("conflict_rsp", 64'h55);
      push("conflict_count", {32'd0, mcnt});
      check(dbg_val); check({32'd0, wr_count});

      // NonReg writes, then a stalled write
      @(negedge clk);
      dstE = 4'hF; dstM = 4'hF; valE = 64'hDEAD; valM = 64'hBEEF;
      step();
      @(negedge clk);
      dstE = 4'd3; valE = 64'h33; wb_en = 1'b0; dbg_id = 4'd3; srcA = 4'hF;
      step();
      push("stall_reg3", mread(4'd3));
      push("stall_count", {32'd0, mcnt});
      push("nonreg_read", 64'd0);
      check(dbg_val); check({32'd0, wr_count}); check(valA);

      // Read during write
      @(negedge clk);
      dstE = 4'd6; valE = 64'h77; dstM = 4'hF; wb_en = 1'b1;
      srcA = 4'd6; dbg_id = 4'd6;
      #1;
      push("rdw_pre_valA", mread_pre(4'd6));
      push("rdw_pre_dbg", mread_pre(4'd6));
      check(valA); check(dbg_val);
      step();
      push("rdw_post_valA", 64'h77);
      check(valA);

      // Read during write with both ports on the same ID
      @(negedge clk);
      dstE = 4'd7; valE = 64'h1; dstM = 4'd7; valM = 64'h2; srcB = 4'd7;
      #1;
      push("rdw_prio_pre", mread_pre(4'd7));
      check(valB);
      step();
      push("rdw_prio_post", 64'h2);
      push("rdw_prio_count", {32'd0, mcnt});
      check(valB); check({32'd0, wr_count});

      // Counter wrap
      @(negedge clk);
      wb_en = 1'b0;
      force dut.r_wr_count = 32'hFFFF_FFFF;
      #1;
      release dut.r_wr_count;
      mcnt = 32'hFFFF_FFFF;
      @(negedge clk);
      dstE = 4'd8; valE = 64'h88; dstM = 4'd9; valM = 64'h99; wb_en = 1'b1;
      srcA = 4'd8; srcB = 4'd9;
      step();
      push("wrap_count", {32'd0, mcnt});
      push("wrap_reg8", mread(4'd8));
      push("wrap_reg9", mread(4'd9));
      check({32'd0, wr_count}); check(valA); check(valB);

      @(negedge clk);
      wb_en = 1'b0;
      checks++;
      assert (exp_q.size() == 0) else begin
         failures++;
         $error("FAIL scoreboard_leftover observed=%0d expected=0", exp_q.size());
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

`default_nettype wire
